// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: RV32I opcode/funct encodings plus fetch reset PC and bubble encoding
package fetch_stage_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h4000_0000;
  localparam logic [31:0] INST_NOP_ENC = 32'h0000_0013;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I fetch PC, sync-read imem interface, stall skid and redirect squash
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] INST_NOP = INST_NOP_ENC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_dout,
  output logic [31:0] inst_d,
  output logic [31:0] pc_d,
  output logic        valid_d,
  output logic [31:0] fetch_cnt
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
  state_t state, state_nx;
  logic [31:0] fpc, fpc_nx, pc_nx, hold_inst, hold_nx;
  logic valid_nx, adv;
  // A redirect overrides stall: the slot advances and the wrong-path fetch is delivered as a bubble
  always_comb begin
    adv = redirect | ~stall;
    fpc_nx = redirect ? {redirect_pc[31:2], 2'b00} : stall ? fpc : fpc + 32'd4;
    state_nx = adv ? RUN : (state == BOOT ? BOOT : HOLD);
    pc_nx = adv ? fpc : pc_d;
    valid_nx = adv ? ~redirect : valid_d;
    hold_nx = (state == RUN && !adv) ? imem_dout : hold_inst;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      fpc <= RESET_PC;
      pc_d <= '0;
      valid_d <= 1'b0;
      hold_inst <= INST_NOP;
      fetch_cnt <= '0;
    end else begin
      state <= state_nx;
      fpc <= fpc_nx;
      pc_d <= pc_nx;
      valid_d <= valid_nx;
      hold_inst <= hold_nx;
      fetch_cnt <= fetch_cnt + {31'd0, valid_d & ~stall};
    end
  end
  assign imem_addr = fpc;
  assign imem_en = ~rst;
  assign inst_d = !valid_d ? INST_NOP : state == HOLD ? hold_inst : imem_dout;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus random stimulus against a slot-level fetch model
module tb_fetch_stage;
  import fetch_stage_pkg::*;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0, imem_dout = '0;
  logic [31:0] imem_addr, inst_d, pc_d, fetch_cnt;
  logic imem_en, valid_d;
  int tests = 0, fails = 0;
  logic [31:0] nxt, epc, einst, cnt;
  logic ev;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_dout(imem_dout),
    .inst_d(inst_d), .pc_d(pc_d), .valid_d(valid_d), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h55AA_0F0F;
  endfunction

  always @(posedge clk) imem_dout <= memf(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    nxt = RESET_PC_DEF;
    epc = '0;
    einst = INST_NOP_ENC;
    ev = 1'b0;
    cnt = '0;
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, nxt);
    chk("imem_en", {31'd0, imem_en}, 32'd1);
    chk("valid_d", {31'd0, valid_d}, {31'd0, ev});
    chk("pc_d", pc_d, epc);
    chk("inst_d", inst_d, einst);
    chk("fetch_cnt", fetch_cnt, cnt);
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] t);
    stall = s;
    redirect = r;
    redirect_pc = t;
    @(posedge clk);
    if (r || !s) begin
      if (ev && !s) cnt = cnt + 32'd1;
      ev = !r;
      epc = nxt;
      einst = r ? INST_NOP_ENC : memf(nxt);
      nxt = r ? {t[31:2], 2'b00} : nxt + 32'd4;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    chk("rst_inst", inst_d, INST_NOP_ENC);
    chk("rst_pc", pc_d, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC_DEF);
    chk("rst_en", {31'd0, imem_en}, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    rst = 1'b0;
    #1 check_all();
    step(1'b0, 1'b0, '0);
    chk("boot_pc", pc_d, 32'h4000_0000);
    chk("boot_addr", imem_addr, 32'h4000_0004);
    step(1'b0, 1'b0, '0);
    chk("seq_addr", imem_addr, 32'h4000_0008);
    step(1'b0, 1'b0, '0);
    chk("seq_pc", pc_d, 32'h4000_0008);
    repeat (3) begin
      step(1'b1, 1'b0, $urandom);
      chk("stall_pc", pc_d, 32'h4000_0008);
      chk("stall_inst", inst_d, memf(32'h4000_0008));
    end
    step(1'b0, 1'b0, '0);
    chk("after_stall_pc", pc_d, 32'h4000_000C);
    step(1'b0, 1'b1, 32'h4000_0103);
    chk("redir_addr", imem_addr, 32'h4000_0100);
    chk("redir_bubble", inst_d, 32'h0000_0013);
    step(1'b0, 1'b0, '0);
    chk("redir_tgt_pc", pc_d, 32'h4000_0100);
    chk("redir_tgt_valid", {31'd0, valid_d}, 32'd1);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 32'h4000_0202);
    chk("hold_redir_addr", imem_addr, 32'h4000_0200);
    step(1'b1, 1'b0, '0);
    chk("no_hold_reappear", inst_d, INST_NOP_ENC);
    step(1'b0, 1'b0, '0);
    chk("hold_redir_pc", pc_d, 32'h4000_0200);
    force dut.fetch_cnt = 32'hFFFF_FFFF;
    #1 release dut.fetch_cnt;
    cnt = 32'hFFFF_FFFF;
    step(1'b0, 1'b0, '0);
    chk("cnt_wrap0", fetch_cnt, 32'd0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("cnt_wrap1", fetch_cnt, 32'd1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, valid_d}, 32'd0);
    chk("arst_inst", inst_d, INST_NOP_ENC);
    chk("arst_pc", pc_d, 32'd0);
    chk("arst_addr", imem_addr, RESET_PC_DEF);
    chk("arst_en", {31'd0, imem_en}, 32'd0);
    chk("arst_cnt", fetch_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, '0);
    chk("restart_pc", pc_d, RESET_PC_DEF);
    chk("restart_valid", {31'd0, valid_d}, 32'd1);
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
